// File: rtl/cpu_ctrl_if.sv
// Control bundle between the RV32I multi-cycle controller (master) and the
// datapath / memory side (slave): decoded opcode, ready handshakes, selects and enables.
interface cpu_ctrl_if #(
  parameter int CAUSE_W = 2
);
  logic [6:0]         opcode;
  logic               branch_taken;
  logic               imem_ready;
  logic               dmem_ready;
  logic               imem_req;
  logic               ir_we;
  logic               dmem_req;
  logic               dmem_we;
  logic               pc_we;
  logic [1:0]         pc_sel;
  logic               alu_a_sel;
  logic               alu_b_sel;
  logic               rf_we;
  logic [1:0]         wb_sel;
  logic               halt;
  logic [CAUSE_W-1:0] trap_cause;

  modport master (
    input  opcode, branch_taken, imem_ready, dmem_ready,
    output imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel,
           alu_a_sel, alu_b_sel, rf_we, wb_sel, halt, trap_cause
  );

  modport slave (
    output opcode, branch_taken, imem_ready, dmem_ready,
    input  imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel,
           alu_a_sel, alu_b_sel, rf_we, wb_sel, halt, trap_cause
  );
endinterface

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP sequencing.
// Optional performance counters (instret, cycle_cnt) are built when CPU_CTRL_PERF_CNT_EN is defined.
module cpu_ctrl_fsm #(
  parameter int RESET_TRAP_CODE = 0,
  parameter int CAUSE_W         = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  cpu_ctrl_if.master  bus
`ifdef CPU_CTRL_PERF_CNT_EN
  ,
  output logic [31:0] instret,
  output logic [31:0] cycle_cnt
`endif
);

  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP} state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL = CAUSE_W'(1);
  localparam logic [CAUSE_W-1:0] CAUSE_SYSTEM  = CAUSE_W'(2);
  localparam logic [CAUSE_W-1:0] CAUSE_IDLE    = CAUSE_W'(RESET_TRAP_CODE);

  state_t             state_q, state_d;
  logic [6:0]         opcode_q, opcode_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;

  logic       imem_req, ir_we, dmem_req, dmem_we, pc_we, rf_we, halt;
  logic       alu_a_sel, alu_b_sel;
  logic [1:0] pc_sel, wb_sel;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE,
      OP_ALUI, OP_ALU, OP_FENCE, OP_SYSTEM: is_legal = 1'b1;
      default:                              is_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FETCH;
      opcode_q <= '0;
      cause_q  <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      cause_q  <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    cause_d   = cause_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    halt      = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        opcode_d = bus.opcode;
        if (!is_legal(bus.opcode)) begin
          state_d = TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (bus.opcode == OP_SYSTEM) begin
          state_d = TRAP;
          cause_d = CAUSE_SYSTEM;
        end else begin
          state_d = EXECUTE;
        end
      end
      // Operands are only steered here; later states consume the datapath's ALU output register.
      EXECUTE: begin
        case (opcode_q)
          OP_AUIPC, OP_JAL, OP_BRANCH: begin
            alu_a_sel = 1'b1;
            alu_b_sel = 1'b1;
          end
          OP_JALR, OP_ALUI, OP_LOAD, OP_STORE: alu_b_sel = 1'b1;
          default: ;
        endcase
        case (opcode_q)
          OP_BRANCH: begin
            pc_we   = 1'b1;
            pc_sel  = bus.branch_taken ? 2'd1 : 2'd0;
            state_d = FETCH;
          end
          OP_FENCE: begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end
          OP_LOAD, OP_STORE: state_d = MEM;
          default:           state_d = WRITEBACK;
        endcase
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode_q == OP_STORE);
        if (bus.dmem_ready) begin
          if (opcode_q == OP_STORE) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WRITEBACK;
          end
        end
      end
      WRITEBACK: begin
        rf_we   = 1'b1;
        pc_we   = 1'b1;
        state_d = FETCH;
        case (opcode_q)
          OP_JAL:  begin pc_sel = 2'd1; wb_sel = 2'd2; end
          OP_JALR: begin pc_sel = 2'd2; wb_sel = 2'd2; end
          OP_LOAD: wb_sel = 2'd1;
          OP_LUI:  wb_sel = 2'd3;
          default: ;
        endcase
      end
      TRAP:    halt = 1'b1;
      default: state_d = FETCH;
    endcase
  end

  // Outputs are gated by rst_n so an in-flight request or enable drops the instant reset asserts.
  assign bus.imem_req   = rst_n & imem_req;
  assign bus.ir_we      = rst_n & ir_we;
  assign bus.dmem_req   = rst_n & dmem_req;
  assign bus.dmem_we    = rst_n & dmem_we;
  assign bus.pc_we      = rst_n & pc_we;
  assign bus.pc_sel     = rst_n ? pc_sel : 2'd0;
  assign bus.alu_a_sel  = rst_n & alu_a_sel;
  assign bus.alu_b_sel  = rst_n & alu_b_sel;
  assign bus.rf_we      = rst_n & rf_we;
  assign bus.wb_sel     = rst_n ? wb_sel : 2'd0;
  assign bus.halt       = rst_n & halt;
  assign bus.trap_cause = (rst_n && state_q == TRAP) ? cause_q : CAUSE_IDLE;

`ifdef CPU_CTRL_PERF_CNT_EN
  logic [31:0] instret_q, instret_d, cycle_cnt_q, cycle_cnt_d;

  always_comb begin
    cycle_cnt_d = (state_q == TRAP) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
    instret_d   = instret_q;
    if (state_d == FETCH &&
        (state_q == EXECUTE || state_q == MEM || state_q == WRITEBACK))
      instret_d = instret_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret_q   <= '0;
      cycle_cnt_q <= '0;
    end else begin
      instret_q   <= instret_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

  assign instret   = instret_q;
  assign cycle_cnt = cycle_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm: per-cycle output vectors against hand-derived expectations.
module tb_cpu_ctrl_fsm;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  cpu_ctrl_if #(.CAUSE_W(2)) bus ();

`ifdef CPU_CTRL_PERF_CNT_EN
  logic [31:0] instret, cycle_cnt;
`endif

  cpu_ctrl_fsm #(.RESET_TRAP_CODE(0), .CAUSE_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef CPU_CTRL_PERF_CNT_EN
    ,
    .instret   (instret),
    .cycle_cnt (cycle_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: imem_req ir_we dmem_req dmem_we pc_we pc_sel[2] a_sel b_sel rf_we wb_sel[2] halt cause[2]
  logic [14:0] obs;
  assign obs = {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.pc_we, bus.pc_sel,
                bus.alu_a_sel, bus.alu_b_sel, bus.rf_we, bus.wb_sel, bus.halt, bus.trap_cause};

  localparam logic [14:0] V_IDLE   = 15'b0_0_0_0_0_00_0_0_0_00_0_00;
  localparam logic [14:0] V_FHIT   = 15'b1_1_0_0_0_00_0_0_0_00_0_00;
  localparam logic [14:0] V_FWAIT  = 15'b1_0_0_0_0_00_0_0_0_00_0_00;
  localparam logic [14:0] V_EX_B   = 15'b0_0_0_0_0_00_0_1_0_00_0_00;
  localparam logic [14:0] V_EX_AB  = 15'b0_0_0_0_0_00_1_1_0_00_0_00;
  localparam logic [14:0] V_WB_ALU = 15'b0_0_0_0_1_00_0_0_1_00_0_00;
  localparam logic [14:0] V_M_LD   = 15'b0_0_1_0_0_00_0_0_0_00_0_00;
  localparam logic [14:0] V_WB_LD  = 15'b0_0_0_0_1_00_0_0_1_01_0_00;
  localparam logic [14:0] V_M_ST   = 15'b0_0_1_1_1_00_0_0_0_00_0_00;
  localparam logic [14:0] V_BR_T   = 15'b0_0_0_0_1_01_1_1_0_00_0_00;
  localparam logic [14:0] V_BR_NT  = 15'b0_0_0_0_1_00_1_1_0_00_0_00;
  localparam logic [14:0] V_FENCE  = 15'b0_0_0_0_1_00_0_0_0_00_0_00;
  localparam logic [14:0] V_WB_JR  = 15'b0_0_0_0_1_10_0_0_1_10_0_00;
  localparam logic [14:0] V_WB_J   = 15'b0_0_0_0_1_01_0_0_1_10_0_00;
  localparam logic [14:0] V_WB_LUI = 15'b0_0_0_0_1_00_0_0_1_11_0_00;
  localparam logic [14:0] V_TRAP1  = 15'b0_0_0_0_0_00_0_0_0_00_1_01;
  localparam logic [14:0] V_TRAP2  = 15'b0_0_0_0_0_00_0_0_0_00_1_10;

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.opcode = 7'b0010011;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    bus.branch_taken = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs !== V_IDLE) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want %b", obs, V_IDLE);
    end
`ifdef CPU_CTRL_PERF_CNT_EN
    vectors++;
    if (instret !== 32'd0 || cycle_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_counters got %0d/%0d want 0/0", instret, cycle_cnt);
    end
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== V_FHIT) begin
      miscompares++;
      $display("FAIL reset_first_fetch got %b want %b", obs, V_FHIT);
    end
  endtask

  task automatic test_alui();
    logic [14:0] e;
    apply_reset();
    bus.opcode = 7'b0010011;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      case (c)
        0, 4:    e = V_FHIT;
        1:       e = V_IDLE;
        2:       e = V_EX_B;
        default: e = V_WB_ALU;
      endcase
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL alui cycle %0d got %b want %b", c, obs, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_load_wait();
    logic [14:0] e;
    apply_reset();
    bus.opcode = 7'b0000011;
    bus.imem_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      bus.dmem_ready = (c == 2 || c == 6);
      @(negedge clk);
      case (c)
        0, 8:    e = V_FHIT;
        1:       e = V_IDLE;
        2:       e = V_EX_B;
        7:       e = V_WB_LD;
        default: e = V_M_LD;
      endcase
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL load_wait cycle %0d got %b want %b", c, obs, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_store_imem_wait();
    logic [14:0] e;
    apply_reset();
    bus.opcode = 7'b0100011;
    bus.dmem_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.imem_ready = (c >= 2);
      @(negedge clk);
      case (c)
        0, 1:    e = V_FWAIT;
        2, 6:    e = V_FHIT;
        3:       e = V_IDLE;
        4:       e = V_EX_B;
        default: e = V_M_ST;
      endcase
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL store_imem_wait cycle %0d got %b want %b", c, obs, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back_branch();
    logic [14:0] e;
    apply_reset();
    bus.opcode = 7'b1100011;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      bus.branch_taken = (c < 3);
      @(negedge clk);
      case (c)
        0, 3, 6: e = V_FHIT;
        1, 4:    e = V_IDLE;
        2:       e = V_BR_T;
        default: e = V_BR_NT;
      endcase
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL branch cycle %0d got %b want %b", c, obs, e);
      end
      @(posedge clk);
      #1;
    end
    bus.branch_taken = 1'b0;
  endtask

  task automatic test_fence();
    logic [14:0] e;
    apply_reset();
    bus.opcode = 7'b0001111;
    bus.imem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      case (c)
        0, 3:    e = V_FHIT;
        1:       e = V_IDLE;
        default: e = V_FENCE;
      endcase
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL fence cycle %0d got %b want %b", c, obs, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_jumps_upper();
    logic [6:0]  ops   [4];
    logic [14:0] ex_v  [4];
    logic [14:0] wb_v  [4];
    logic [14:0] e;
    ops[0] = 7'b1100111; ex_v[0] = V_EX_B;  wb_v[0] = V_WB_JR;
    ops[1] = 7'b1101111; ex_v[1] = V_EX_AB; wb_v[1] = V_WB_J;
    ops[2] = 7'b0110111; ex_v[2] = V_IDLE;  wb_v[2] = V_WB_LUI;
    ops[3] = 7'b0010111; ex_v[3] = V_EX_AB; wb_v[3] = V_WB_ALU;
    bus.imem_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      apply_reset();
      bus.opcode = ops[k];
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        case (c)
          0, 4:    e = V_FHIT;
          1:       e = V_IDLE;
          2:       e = ex_v[k];
          default: e = wb_v[k];
        endcase
        vectors++;
        if (obs !== e) begin
          miscompares++;
          $display("FAIL jump_upper op %b cycle %0d got %b want %b", ops[k], c, obs, e);
        end
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic test_trap();
    logic [14:0] e;
    apply_reset();
    bus.opcode = 7'b1111111;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b1;
    bus.branch_taken = 1'b1;
    for (int c = 0; c < 22; c++) begin
      @(negedge clk);
      e = (c == 0) ? V_FHIT : (c == 1) ? V_IDLE : V_TRAP1;
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL trap_illegal cycle %0d got %b want %b", c, obs, e);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if (obs !== V_IDLE) begin
      miscompares++;
      $display("FAIL trap_reset_hold got %b want %b", obs, V_IDLE);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== V_FHIT) begin
      miscompares++;
      $display("FAIL trap_exit_fetch got %b want %b", obs, V_FHIT);
    end
    bus.branch_taken = 1'b0;
    apply_reset();
    bus.opcode = 7'b1110011;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      e = (c == 0) ? V_FHIT : (c == 1) ? V_IDLE : V_TRAP2;
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL trap_system cycle %0d got %b want %b", c, obs, e);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_mem();
    logic [14:0] e;
    apply_reset();
    bus.opcode = 7'b0000011;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      case (c)
        0:       e = V_FHIT;
        1:       e = V_IDLE;
        2:       e = V_EX_B;
        default: e = V_M_LD;
      endcase
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL mid_mem cycle %0d got %b want %b", c, obs, e);
      end
      if (c < 3) begin
        @(posedge clk);
        #1;
      end
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (obs !== V_IDLE) begin
      miscompares++;
      $display("FAIL mid_mem_async_drop got %b want %b", obs, V_IDLE);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.dmem_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (obs !== V_FHIT) begin
      miscompares++;
      $display("FAIL mid_mem_refetch got %b want %b", obs, V_FHIT);
    end
  endtask

  task automatic test_back_to_back_alu();
    logic [14:0] e;
    apply_reset();
    bus.opcode = 7'b0110011;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      case (c % 4)
        0:       e = V_FHIT;
        3:       e = V_WB_ALU;
        default: e = V_IDLE;
      endcase
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL alu_b2b cycle %0d got %b want %b", c, obs, e);
      end
      if (c < 12) begin
        @(posedge clk);
        #1;
      end
    end
`ifdef CPU_CTRL_PERF_CNT_EN
    vectors++;
    if (instret !== 32'd3) begin
      miscompares++;
      $display("FAIL perf_instret got %0d want 3", instret);
    end
    vectors++;
    if (cycle_cnt !== 32'd12) begin
      miscompares++;
      $display("FAIL perf_cycle_cnt got %0d want 12", cycle_cnt);
    end
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    bus.opcode = 7'b0;
    bus.branch_taken = 1'b0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    test_reset();
    test_alui();
    test_load_wait();
    test_store_imem_wait();
    test_back_to_back_branch();
    test_fence();
    test_jumps_upper();
    test_trap();
    test_reset_mid_mem();
    test_back_to_back_alu();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cpu_ctrl_fsm.md
Name: cpu_ctrl_fsm

Overview:
- Multi-cycle control unit for the RV32I core. Sequences fetch, decode, execute, memory and writeback over the shared datapath (ALU, register file, immediate generator, PC).
- Decodes opcode from the latched instruction register.
- Drives datapath mux selects and write enables.
- Handshakes with instruction and data memory via req/ready.

Parameters:
- RESET_TRAP_CODE, 0, value driven on trap_cause while not in TRAP.
- CAUSE_W, 2, width of trap_cause.

Ports:
- clk  input  1  core clock
- rst_n  input  1  reset, asynchronous, active-low
- opcode  input  7  instruction[6:0] from IR
- branch_taken  input  1  branch comparator result, valid in EXECUTE
- imem_ready  input  1  instruction memory returns data this cycle
- dmem_ready  input  1  data memory access completes this cycle
- imem_req  output  1  fetch request, held until imem_ready
- ir_we  output  1  latch instruction register
- dmem_req  output  1  data access request, held until dmem_ready
- dmem_we  output  1  data access is a store
- pc_we  output  1  update PC
- pc_sel  output  2  0: PC+4, 1: PC+imm (branch/JAL), 2: ALU result (JALR, bit0 cleared by datapath)
- alu_a_sel  output  1  0: rs1, 1: PC (AUIPC, JAL, branch target)
- alu_b_sel  output  1  0: rs2, 1: imm
- rf_we  output  1  register file write
- wb_sel  output  2  0: ALU, 1: load data, 2: PC+4, 3: imm (LUI)
- halt  output  1  core stopped in TRAP
- trap_cause  output  CAUSE_W  1: illegal opcode, 2: ECALL/EBREAK (SYSTEM)

Behaviour:
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP. All outputs decode from state plus the registered opcode and inputs, with no extra pipeline stage.
- Reset (async, rst_n=0):
  - state=FETCH; opcode register cleared.
  - Every output 0 while rst_n=0, except trap_cause=RESET_TRAP_CODE.
  - After reset release, first cycle is FETCH with imem_req=1.
- FETCH:
  - imem_req=1.
  - On imem_ready: ir_we=1 the same cycle, then go to DECODE.
  - Otherwise stay, holding imem_req.
- DECODE: single cycle; registers opcode.
  - Legal opcodes: 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR, 1100011 BRANCH, 0000011 LOAD, 0100011 STORE, 0010011 ALUI, 0110011 ALU, 0001111 FENCE, 1110011 SYSTEM.
  - Illegal opcode: go to TRAP, cause 1.
  - SYSTEM: go to TRAP, cause 2.
- EXECUTE: ALU operands selected per opcode.
  - BRANCH: alu_a_sel=1, alu_b_sel=1; pc_we=1; pc_sel=1 if branch_taken else 0; next state FETCH.
  - FENCE: pc_we=1, pc_sel=0; next state FETCH (treated as NOP).
  - LOAD/STORE: alu_b_sel=1; next state MEM.
  - All others: next state WRITEBACK.
- MEM:
  - dmem_req=1; dmem_we=1 for STORE.
  - STORE on dmem_ready: pc_we=1, pc_sel=0; next state FETCH.
  - LOAD on dmem_ready: next state WRITEBACK.
  - Otherwise hold.
- WRITEBACK: rf_we=1, pc_we=1; next state FETCH.
  - JAL: pc_sel=1, wb_sel=2.
  - JALR: pc_sel=2, wb_sel=2.
  - LOAD: wb_sel=1.
  - LUI: wb_sel=3.
  - Otherwise wb_sel=0.
  - pc_sel=0 except for JAL/JALR.
- TRAP: halt=1, trap_cause held. No requests, no writes. Sticky until reset.
- Latency with zero-wait memory (ready in first request cycle), in cycles from FETCH to the next FETCH:
  - ALU/ALUI/LUI/AUIPC/JAL/JALR: 4
  - LOAD: 5
  - STORE: 4
  - BRANCH/FENCE: 3
  - Each wait cycle adds 1.
- Boundaries:
  - imem_ready/dmem_ready asserted outside FETCH/MEM: ignored.
  - Ready asserted on the first request cycle completes the access immediately.
  - pc_we and rf_we assert for exactly one cycle per instruction; never in FETCH, DECODE or TRAP.
  - Reset mid-access: requests drop in the same cycle (async); no partial write enable is issued.

Optional Feature:
- Macro CPU_CTRL_PERF_CNT_EN.
- When defined:
  - Adds outputs instret[31:0] and cycle_cnt[31:0], both reset to 0.
  - cycle_cnt increments every cycle except in TRAP.
  - instret increments on each transition into FETCH from EXECUTE, MEM or WRITEBACK.
  - Both wrap 0xFFFFFFFF to 0.
- When undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Reset then ALUI (0010011) with imem_ready=dmem_ready=1 constantly -> imem_req cycle 0; ir_we cycle 0; rf_we=1, pc_we=1, pc_sel=0, wb_sel=0 in cycle 3; FETCH again cycle 4.
- LOAD with dmem_ready delayed 3 cycles -> dmem_req high 4 consecutive cycles, dmem_we=0; then WRITEBACK with wb_sel=1, rf_we=1; 8 cycles total.
- BRANCH with branch_taken=1 then repeated with 0 -> pc_we in cycle 2 with pc_sel=1, then pc_sel=0; rf_we never asserts.
- JALR -> WRITEBACK asserts pc_sel=2, wb_sel=2, rf_we=1; JAL -> pc_sel=1, wb_sel=2.
- Opcode 1111111 -> TRAP after DECODE: halt=1, trap_cause=1; no req/we outputs for 20 cycles; rst_n pulse returns to FETCH. Opcode 1110011 -> trap_cause=2.
- rst_n asserted during MEM with dmem_req=1 -> dmem_req drops without a clock edge; with CPU_CTRL_PERF_CNT_EN, instret=3 after three completed ALU instructions.
